// File: rtl/ts_pacer_pkg.sv
// Shared constants, state encodings and pipeline stage payload for the TS null pacer.
package ts_pacer_pkg;

  localparam int unsigned TS_PKT_WORDS   = 47;
  localparam int unsigned IDX_W          = 6;
  localparam int unsigned MIN_INTERVAL   = 48;
  localparam logic [31:0] NULL_HDR_WORD  = 32'h471FFF10;
  localparam logic [31:0] NULL_FILL_WORD = 32'hFFFFFFFF;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TS_PKT_WORDS - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_STORE,
    W_DROP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_NULL
  } rd_state_t;

  // One output word travelling down the read pipeline
  typedef struct packed {
    logic valid;
    logic start;
    logic last;
    logic is_null;
  } stage_t;

endpackage

// File: rtl/ts_pacer_ram.sv
// Simple dual-port packet store: one 64-word slot per packet, registered read.
module ts_pacer_ram
  import ts_pacer_pkg::*;
#(
  parameter int unsigned P_PKT_SLOTS = 4
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [$clog2(P_PKT_SLOTS)+IDX_W-1:0]  wr_addr,
  input  logic [31:0]                           wr_data,
  input  logic                                  rd_en,
  input  logic [$clog2(P_PKT_SLOTS)+IDX_W-1:0]  rd_addr,
  output logic [31:0]                           rd_data
);

  localparam int unsigned DEPTH = P_PKT_SLOTS * (2 ** IDX_W);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ts_null_pacer.sv
// Buffers whole TS packets and emits one per slot period, filling empty slots with nulls.
// Optional TS_NULL_PACER_STATS_EN adds saturating null_count / drop_count outputs.
module ts_null_pacer
  import ts_pacer_pkg::*;
#(
  parameter int unsigned P_PKT_SLOTS      = 4,
  parameter int unsigned P_INTERVAL_WIDTH = 16
) (
  input  logic                          payload_clk,
  input  logic                          payload_rst,
  input  logic                          payload_in_valid,
  input  logic [31:0]                   payload_in_data,
  input  logic                          payload_in_start,
  input  logic                          payload_in_end,
  input  logic                          cfg_enable,
  input  logic [P_INTERVAL_WIDTH-1:0]   cfg_pkt_interval,
  output logic                          payload_out_valid,
  output logic [31:0]                   payload_out_data,
  output logic                          payload_out_start,
  output logic                          payload_out_end,
  output logic                          overflow,
  output logic [$clog2(P_PKT_SLOTS):0]  pkts_buffered
`ifdef TS_NULL_PACER_STATS_EN
  ,
  output logic [31:0]                   null_count,
  output logic [31:0]                   drop_count
`endif
);

  localparam int unsigned SW = $clog2(P_PKT_SLOTS);
  localparam int unsigned CW = SW + 1;
  localparam int unsigned IW = P_INTERVAL_WIDTH;
  localparam int unsigned AW = SW + IDX_W;

  wr_state_t        w_state, w_state_nx;
  logic [IDX_W-1:0] w_idx, w_idx_nx;
  logic [SW-1:0]    wr_ptr;
  logic             commit_c, mem_we_c, ovf_c, full_c;
  logic [IDX_W-1:0] mem_widx_c;

  rd_state_t        r_state, r_state_nx;
  logic [IDX_W-1:0] r_idx, r_idx_nx;
  logic [SW-1:0]    rd_ptr;
  logic [1:0]       inflight;
  logic             rd_en_c, rd_adv_c, data_start_c, avail_c, free_c;
  logic [IDX_W-1:0] rd_idx_c;
  stage_t           s0, s1;
  logic [31:0]      ram_q;
  logic             out_is_data;

  logic [IW-1:0]    pace_cnt, reload_c;
  logic             tick_c;

  // A slot being freed this cycle is already available to an arriving start
  assign free_c  = payload_out_valid && payload_out_end && out_is_data;
  assign full_c  = (pkts_buffered == CW'(P_PKT_SLOTS)) && !free_c;
  assign avail_c = pkts_buffered > CW'(inflight);

  // Writer next-state
  always_comb begin
    w_state_nx = w_state;
    w_idx_nx   = w_idx;
    commit_c   = 1'b0;
    mem_we_c   = 1'b0;
    mem_widx_c = '0;
    ovf_c      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (payload_in_valid && payload_in_start) begin
          w_idx_nx = IDX_W'(1);
          if (full_c) begin
            ovf_c      = 1'b1;
            w_state_nx = payload_in_end ? W_IDLE : W_DROP;
          end else begin
            mem_we_c   = 1'b1;
            w_state_nx = payload_in_end ? W_IDLE : W_STORE;
          end
        end
      end
      W_STORE: begin
        if (payload_in_valid) begin
          mem_we_c = 1'b1;
          if (payload_in_start) begin
            w_idx_nx   = IDX_W'(1);
            w_state_nx = payload_in_end ? W_IDLE : W_STORE;
          end else begin
            mem_widx_c = w_idx;
            w_idx_nx   = w_idx + IDX_W'(1);
            if (w_idx == LAST_IDX) begin
              w_state_nx = W_IDLE;
              commit_c   = payload_in_end;
            end else if (payload_in_end) begin
              w_state_nx = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (payload_in_valid) begin
          w_idx_nx = w_idx + IDX_W'(1);
          if (payload_in_end || (w_idx == LAST_IDX)) w_state_nx = W_IDLE;
        end
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      w_state  <= W_IDLE;
      w_idx    <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      w_state  <= w_state_nx;
      w_idx    <= w_idx_nx;
      overflow <= ovf_c;
      if (commit_c) wr_ptr <= wr_ptr + SW'(1);
    end
  end

  // Slot pacer: period equals the reload value; held in reload while bypassed
  assign reload_c = (cfg_pkt_interval < IW'(MIN_INTERVAL)) ? IW'(MIN_INTERVAL) : cfg_pkt_interval;
  assign tick_c   = cfg_enable && (pace_cnt == IW'(1));

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      pace_cnt <= '0;
    end else if (!cfg_enable || (pace_cnt <= IW'(1))) begin
      pace_cnt <= reload_c;
    end else begin
      pace_cnt <= pace_cnt - IW'(1);
    end
  end

  // Reader next-state; word 0 is addressed in the same cycle as the slot tick
  always_comb begin
    r_state_nx   = r_state;
    r_idx_nx     = r_idx;
    s0           = '0;
    rd_en_c      = 1'b0;
    rd_idx_c     = '0;
    rd_adv_c     = 1'b0;
    data_start_c = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (cfg_enable ? (tick_c && avail_c) : avail_c) begin
          data_start_c = 1'b1;
          rd_en_c      = 1'b1;
          s0.valid     = 1'b1;
          s0.start     = 1'b1;
          r_idx_nx     = IDX_W'(1);
          r_state_nx   = R_DATA;
        end else if (tick_c) begin
          s0.valid   = 1'b1;
          s0.start   = 1'b1;
          s0.is_null = 1'b1;
          r_idx_nx   = IDX_W'(1);
          r_state_nx = R_NULL;
        end
      end
      R_DATA: begin
        rd_en_c  = 1'b1;
        rd_idx_c = r_idx;
        s0.valid = 1'b1;
        r_idx_nx = r_idx + IDX_W'(1);
        if (r_idx == LAST_IDX) begin
          s0.last    = 1'b1;
          rd_adv_c   = 1'b1;
          r_state_nx = R_IDLE;
        end
      end
      R_NULL: begin
        s0.valid   = 1'b1;
        s0.is_null = 1'b1;
        r_idx_nx   = r_idx + IDX_W'(1);
        if (r_idx == LAST_IDX) begin
          s0.last    = 1'b1;
          r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      rd_ptr  <= '0;
      s1      <= '0;
    end else begin
      r_state <= r_state_nx;
      r_idx   <= r_idx_nx;
      s1      <= s0;
      if (rd_adv_c) rd_ptr <= rd_ptr + SW'(1);
    end
  end

  // Occupancy: packets committed but not yet fully emitted, plus reads in progress
  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      pkts_buffered <= '0;
      inflight      <= '0;
    end else begin
      case ({commit_c, free_c})
        2'b10:   pkts_buffered <= pkts_buffered + CW'(1);
        2'b01:   pkts_buffered <= pkts_buffered - CW'(1);
        default: pkts_buffered <= pkts_buffered;
      endcase
      case ({data_start_c, free_c})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  ts_pacer_ram #(
    .P_PKT_SLOTS(P_PKT_SLOTS)
  ) u_ram (
    .clk     (payload_clk),
    .wr_en   (mem_we_c),
    .wr_addr (AW'({wr_ptr, mem_widx_c})),
    .wr_data (payload_in_data),
    .rd_en   (rd_en_c),
    .rd_addr (AW'({rd_ptr, rd_idx_c})),
    .rd_data (ram_q)
  );

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      payload_out_valid <= 1'b0;
      payload_out_start <= 1'b0;
      payload_out_end   <= 1'b0;
      payload_out_data  <= '0;
      out_is_data       <= 1'b0;
    end else begin
      payload_out_valid <= s1.valid;
      payload_out_start <= s1.valid && s1.start;
      payload_out_end   <= s1.valid && s1.last;
      out_is_data       <= s1.valid && !s1.is_null;
      if (!s1.valid) begin
        payload_out_data <= '0;
      end else if (s1.is_null) begin
        payload_out_data <= s1.start ? NULL_HDR_WORD : NULL_FILL_WORD;
      end else begin
        payload_out_data <= ram_q;
      end
    end
  end

`ifdef TS_NULL_PACER_STATS_EN
  logic null_start_c;
  assign null_start_c = s0.valid && s0.start && s0.is_null;

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      null_count <= '0;
      drop_count <= '0;
    end else begin
      if (null_start_c && (null_count != '1)) null_count <= null_count + 32'd1;
      if (ovf_c && (drop_count != '1)) drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ts_null_pacer.sv
// Scoreboard bench for ts_null_pacer: expected packet ids queued at stimulus, checked by a monitor.
module tb_ts_null_pacer;
  import ts_pacer_pkg::*;

  logic        clk = 1'b0;
  logic        payload_rst = 1'b1;
  logic        in_valid = 1'b0, in_start = 1'b0, in_end = 1'b0;
  logic [31:0] in_data = '0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_interval = 16'd100;
  logic        payload_out_valid, payload_out_start, payload_out_end, overflow;
  logic [31:0] payload_out_data;
  logic [2:0]  pkts_buffered;
`ifdef TS_NULL_PACER_STATS_EN
  logic [31:0] null_count, drop_count;
`endif

  always #5 clk = ~clk;

  ts_null_pacer #(.P_PKT_SLOTS(4), .P_INTERVAL_WIDTH(16)) dut (
    .payload_clk      (clk),
    .payload_rst      (payload_rst),
    .payload_in_valid (in_valid),
    .payload_in_data  (in_data),
    .payload_in_start (in_start),
    .payload_in_end   (in_end),
    .cfg_enable       (cfg_enable),
    .cfg_pkt_interval (cfg_interval),
    .payload_out_valid(payload_out_valid),
    .payload_out_data (payload_out_data),
    .payload_out_start(payload_out_start),
    .payload_out_end  (payload_out_end),
    .overflow         (overflow),
    .pkts_buffered    (pkts_buffered)
`ifdef TS_NULL_PACER_STATS_EN
    ,
    .null_count       (null_count),
    .drop_count       (drop_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];
  int log_t[$];
  int log_n[$];
  int ovf_cnt = 0, ovf_cyc = -1, peak = 0, null_seen = 0;
  bit mon_abort = 1'b0;

  bit          collecting = 1'b0, m_null = 1'b0, m_bad = 1'b0;
  int          m_idx = 0, m_id = 0, bad_idx = 0;
  logic [31:0] m_exp, bad_got, bad_exp;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] gen_word(input int id, input int i);
    logic [7:0]  a, b;
    logic [15:0] c;
    a = 8'(id);
    b = 8'(i);
    c = 16'(id * i + 32'h5A5A);
    if (i == 0) return {8'h47, a, 16'h0100};
    return {a, b, c};
  endfunction

  function automatic int get_t(input int i);
    return (i < log_t.size()) ? log_t[i] : -100000;
  endfunction

  function automatic int get_n(input int i);
    return (i < log_n.size()) ? log_n[i] : 2;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Output monitor: every packet is compared word by word against its expected content
  always @(negedge clk) begin
    if (overflow) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
    if (int'(pkts_buffered) > peak) peak = int'(pkts_buffered);
    if (payload_out_valid) begin
      if (payload_out_start) begin
        if (collecting) begin
          checks++; errors++;
          $display("FAIL pkt_start_mid_packet: start seen at word %0d, required at word 0", m_idx);
        end
        collecting = 1'b1;
        m_idx = 0;
        m_bad = 1'b0;
        m_null = (payload_out_data == NULL_HDR_WORD);
        log_t.push_back(cyc);
        log_n.push_back(m_null ? 1 : 0);
        if (m_null) begin
          null_seen++;
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pkt_unexpected: data packet hdr %08h with none expected", payload_out_data);
          m_id = -1;
        end else begin
          m_id = exp_q.pop_front();
        end
      end
      if (collecting) begin
        m_exp = m_null ? ((m_idx == 0) ? NULL_HDR_WORD : NULL_FILL_WORD) : gen_word(m_id, m_idx);
        if (!m_bad && ((payload_out_data !== m_exp) || (payload_out_end !== (m_idx == 46)))) begin
          m_bad = 1'b1;
          bad_idx = m_idx;
          bad_got = payload_out_data;
          bad_exp = m_exp;
        end
        if ((m_idx == 46) || payload_out_end) begin
          checks++;
          if (m_bad || (m_idx != 46)) begin
            errors++;
            $display("FAIL pkt_content id=%0d null=%0d: word %0d got %08h expected %08h, length %0d expected 47",
                     m_id, m_null, bad_idx, bad_got, bad_exp, m_idx + 1);
          end
          collecting = 1'b0;
        end
        m_idx++;
      end else begin
        checks++; errors++;
        $display("FAIL pkt_stray_word: got word %08h outside a packet, expected none", payload_out_data);
      end
    end else if (collecting) begin
      checks++; errors++;
      $display("FAIL pkt_gap: valid dropped at word %0d, required 47 consecutive words", m_idx);
      collecting = 1'b0;
    end
    if (mon_abort) collecting = 1'b0;
  end

  task automatic do_reset();
    mon_abort = 1'b1;
    payload_rst = 1'b1;
    in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete(); log_t.delete(); log_n.delete();
    ovf_cnt = 0; ovf_cyc = -1; peak = 0; null_seen = 0;
    payload_rst = 1'b0;
    mon_abort = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit s, input bit e);
    in_valid = 1'b1; in_data = d; in_start = s; in_end = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_data = '0;
  endtask

  task automatic send_pkt(input int id, input int nwords, input int end_at);
    for (int i = 0; i < nwords; i++) send_word(gen_word(id, i), i == 0, i == end_at);
  endtask

  task automatic wait_starts(input string name, input int n, input int budget);
    int t = 0;
    while (log_t.size() < n && t < budget) begin
      @(posedge clk); #1; t++;
    end
    chk(name, log_t.size() >= n ? n : log_t.size(), n);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk); #1; t++;
    end
    chk(name, exp_q.size(), 0);
    repeat (55) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, int'(payload_out_valid), 0);
    chk({tag, "_start"}, int'(payload_out_start), 0);
    chk({tag, "_end"}, int'(payload_out_end), 0);
    chk({tag, "_data"}, int'(payload_out_data), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_pkts_buffered"}, int'(pkts_buffered), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c5, t;

    // Pacing: one data packet, then nulls every 100 clocks
    cfg_enable = 1'b1; cfg_interval = 16'd100;
    do_reset();
    chk_outputs_zero("reset");
    exp_q.push_back(1);
    send_pkt(1, 47, 46);
    idle();
    chk("pace_committed", int'(pkts_buffered), 1);
    wait_starts("pace_starts", 3, 400);
    repeat (50) @(posedge clk);
    #1;
    chk("pace_first_is_data", get_n(0), 0);
    chk("pace_second_is_null", get_n(1), 1);
    chk("pace_third_is_null", get_n(2), 1);
    chk("pace_spacing_0_1", get_t(1) - get_t(0), 100);
    chk("pace_spacing_1_2", get_t(2) - get_t(1), 100);
    chk("pace_queue_empty", exp_q.size(), 0);
    chk("pace_freed", int'(pkts_buffered), 0);

    // Minimum interval clamps the slot period to 48
    cfg_interval = 16'd10;
    do_reset();
    wait_starts("min_starts", 3, 300);
    repeat (50) @(posedge clk);
    #1;
    chk("min_null", get_n(0), 1);
    chk("min_spacing_0_1", get_t(1) - get_t(0), 48);
    chk("min_spacing_1_2", get_t(2) - get_t(1), 48);

    // Overflow: fifth back-to-back packet is dropped
    cfg_interval = 16'd1000;
    do_reset();
    for (int k = 1; k <= 4; k++) exp_q.push_back(k);
    c5 = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) c5 = cyc;
      send_pkt(k, 47, 46);
    end
    idle();
    chk("ovf_pulses", ovf_cnt, 1);
    chk("ovf_cycle", ovf_cyc, c5 + 1);
    chk("ovf_full", int'(pkts_buffered), 4);
    wait_drain("ovf_drain", 6000);
    chk("ovf_first_is_data", get_n(0), 0);
    chk("ovf_fourth_is_data", get_n(3), 0);
    chk("ovf_no_null", null_seen, 0);
    chk("ovf_empty", int'(pkts_buffered), 0);

    // Malformed input: short packet, restarted packet, then a good one
    cfg_interval = 16'd100;
    do_reset();
    exp_q.push_back(7);
    send_pkt(5, 31, 30);
    send_pkt(6, 20, -1);
    send_pkt(7, 47, 46);
    idle();
    chk("bad_committed", int'(pkts_buffered), 1);
    wait_drain("bad_drain", 400);
    chk("bad_peak", peak, 1);
    chk("bad_overflow", ovf_cnt, 0);

    // Bypass: three packets out back-to-back, no nulls
    cfg_enable = 1'b0;
    do_reset();
    for (int k = 1; k <= 3; k++) exp_q.push_back(k + 20);
    for (int k = 1; k <= 3; k++) send_pkt(k + 20, 47, 46);
    idle();
    wait_starts("byp_starts", 3, 300);
    repeat (60) @(posedge clk);
    #1;
    chk("byp_spacing_0_1", get_t(1) - get_t(0), 47);
    chk("byp_spacing_1_2", get_t(2) - get_t(1), 47);
    chk("byp_no_null", null_seen, 0);
    chk("byp_queue_empty", exp_q.size(), 0);

    // Reset during emission, then a fresh packet
    do_reset();
    exp_q.push_back(9);
    send_pkt(9, 47, 46);
    idle();
    t = 0;
    while (!payload_out_start && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("rst_out_started", int'(payload_out_start), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_word20", int'(payload_out_data), int'(gen_word(9, 20)));
    mon_abort = 1'b1;
    payload_rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("rst_mid");
    do_reset();
    exp_q.push_back(10);
    send_pkt(10, 47, 46);
    idle();
    wait_drain("rst_after_drain", 200);
    chk("rst_after_empty", int'(pkts_buffered), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_null_pacer.md
Name: ts_null_pacer

Overview:
- Downstream of the TS-processing output port: consumes 188-byte TS packets as 47 x 32-bit words (valid/start/end, no backpressure).
- Buffers whole packets and emits one packet per programmable slot period, producing a constant-rate stream for the output/modulator side.
- Fills empty slots with DVB null packets (PID 0x1FFF).

Parameters:
- P_PKT_SLOTS, 4, buffer capacity in whole packets (power of 2, 2..16).
- P_INTERVAL_WIDTH, 16, width of the slot-period configuration.

Ports:
- payload_clk  in  1  block clock
- payload_rst  in  1  synchronous active-high reset
- payload_in_valid  in  1  input word strobe
- payload_in_data  in  32  input TS word, byte 0 in [31:24]
- payload_in_start  in  1  first word of packet
- payload_in_end  in  1  last word of packet
- cfg_enable  in  1  1 = paced with null fill; 0 = bypass pacing
- cfg_pkt_interval  in  P_INTERVAL_WIDTH  slot period in clocks
- payload_out_valid  out  1  output word strobe
- payload_out_data  out  32  output TS word
- payload_out_start  out  1  first output word
- payload_out_end  out  1  last output word
- overflow  out  1  one-cycle pulse when an input packet is dropped because the buffer is full
- pkts_buffered  out  $clog2(P_PKT_SLOTS)+1  complete packets held

Behaviour:
- Clock and reset: one clock, payload_clk. payload_rst is synchronous and active-high. On reset, all outputs are 0, pointers and counters clear, and the FSMs go idle.
- Writer FSM states: W_IDLE, W_STORE, W_DROP.
  - Valid+start in W_IDLE: go to W_STORE if fewer than P_PKT_SLOTS packets are held; otherwise go to W_DROP and pulse overflow.
  - Word index counts 0..46.
  - Packet commit (pkts_buffered +1) happens only when end coincides with index 46.
  - End at any other index, index 46 without end, or start in mid-packet: discard the partial packet by rewinding the write slot. A start in mid-packet restarts as a new packet.
  - W_DROP leaves on end, or after 47 words.
  - Valid without start in W_IDLE: ignored.
- Pacer: down-counter loaded with max(cfg_pkt_interval, 48). Reaching 0 gives a slot tick and a reload. A cfg change takes effect on the next reload.
- Reader FSM states: R_IDLE, R_DATA, R_NULL.
  - On a slot tick: R_DATA if pkts_buffered > 0, else R_NULL (only when cfg_enable = 1).
  - With cfg_enable = 0: R_DATA starts whenever a packet is held and the reader is idle. No nulls are sent and the pacer is held in reload.
  - Each packet is 47 consecutive valid cycles: start on word 0, end on word 46. The slot is freed (pkts_buffered -1) in the cycle end is output.
- Latency: payload_out_start asserts 2 clocks after the slot tick (1 cycle RAM read + output register).
- Null packet content: word 0 = 0x471FFF10, words 1..46 = 0xFFFFFFFF.
- Simultaneous commit and free in one cycle: pkts_buffered is unchanged.
- Pointer wrap: write and read slot indices wrap modulo P_PKT_SLOTS.
- A packet emitted with pkts_buffered = P_PKT_SLOTS frees a slot before the next input start can be dropped, when the two coincide.

Optional Feature:
- Macro: TS_NULL_PACER_STATS_EN.
- Defined: adds outputs null_count[31:0] and drop_count[31:0]. Both saturate, clear on reset, and increment on null start and on overflow respectively.
- Not defined: these ports are absent and there is no counter logic.

Decomposition:
- Package ts_pacer_pkg holds: TS_PKT_WORDS = 47, NULL_HDR_WORD = 32'h471FFF10, NULL_FILL_WORD = 32'hFFFFFFFF, MIN_INTERVAL = 48, and the writer/reader state enums.
- Sub-module ts_pacer_ram: simple dual-port RAM, P_PKT_SLOTS*64 words x 32, registered read. Each slot has a 64-word stride and is addressed as {slot, index}.

Test Plan:
- Pacing: cfg_enable=1, interval=100, one valid packet in -> data packet starts 2 clocks after the next tick. Subsequent starts are exactly 100 clocks apart and are nulls (word 0 0x471FFF10).
- Minimum interval: interval=10 -> start-to-start spacing of 48 clocks; a 1-clock gap between packets.
- Overflow: P_PKT_SLOTS=4, interval=1000, 5 packets back-to-back -> overflow pulses once on the 5th start; pkts_buffered=4; the output carries packets 1..4 in order.
- Malformed input: packet with end at word 30, then a good packet -> only the good packet is output; pkts_buffered peaks at 1.
- Bypass: cfg_enable=0, 3 packets in -> 3 packets out back-to-back; no null words appear.
- Reset mid-emission: assert payload_rst at word 20 of output -> next cycle all outputs are 0 and pkts_buffered=0; a new packet after reset is output intact.
